// File: rtl/bcd_cnt_pkg.sv
// Shared constants and elaboration-time helpers for the BCD modulo counter.
package bcd_cnt_pkg;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX     = 4'd9;

    // Binary to packed BCD for up to four digits. This is used only on
    // parameters to build the terminal value, so the divisions never become
    // hardware.
    function automatic logic [15:0] to_bcd(input int value, input int ndig);
        logic [15:0] r;
        int          v;
        r = '0;
        v = value;
        for (int i = 0; i < 4; i++) begin
            if (i < ndig) begin
                r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'(v % 10);
            end
            v = v / 10;
        end
        return r;
    endfunction

    // True when every one of the low ndig digits is a legal decimal digit.
    function automatic logic bcd_valid(input logic [15:0] vec, input int ndig);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < ndig && vec[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_mod_counter_digit.sv
// One decade of the BCD counter: increments or decrements with decimal
// carry/borrow. A wrap request forces the digit to its wrap value.
module bcd_digit
    import bcd_cnt_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d_in,
    input  logic                   up_dn,
    input  logic                   c_in,
    input  logic                   wrap,
    input  logic [BCD_DIGIT_W-1:0] wrap_val,
    output logic [BCD_DIGIT_W-1:0] d_out,
    output logic                   c_out
);

    // The ripple out does not depend on wrap. The top derives its down-wrap
    // detect from the last ripple, so this path must stay free of wrap.
    assign c_out = c_in & (up_dn ? (d_in == BCD_MAX) : (d_in == 4'd0));

    // Next digit value: wrap wins; otherwise step only when the lower digits ripple.
    always_comb begin
        d_out = d_in;
        if (wrap) begin
            d_out = wrap_val;
        end else if (c_in) begin
            if (up_dn) begin
                d_out = (d_in == BCD_MAX) ? 4'd0 : d_in + 4'd1;
            end else begin
                d_out = (d_in == 4'd0) ? BCD_MAX : d_in - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// Parametrised BCD modulo counter stage with up/down, clear, load and a
// same-cycle terminal-count output (co) for cascading.
// Optional lap/split display is enabled with macro BCD_CNT_LAP_EN.
module bcd_mod_counter
    import bcd_cnt_pkg::*;
#(
    parameter int NDIG    = 2,
    parameter int MODULUS = 60
)
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          up_dn,
    input  logic                          clr,
    input  logic                          load,
    input  logic [BCD_DIGIT_W*NDIG-1:0]   load_val,
    output logic [BCD_DIGIT_W*NDIG-1:0]   bcd,
    output logic                          co,
    output logic                          load_err
`ifdef BCD_CNT_LAP_EN
    ,
    input  logic                          lap,
    output logic                          lap_active
`endif
);

    localparam int            W  = BCD_DIGIT_W * NDIG;
    localparam logic [W-1:0]  TV = W'(to_bcd(MODULUS - 1, NDIG));

    if (NDIG < 1 || NDIG > 4) begin : g_bad_ndig
        $error("bcd_mod_counter: NDIG must be 1..4");
    end
    if (MODULUS < 2 || MODULUS > 10**NDIG) begin : g_bad_mod
        $error("bcd_mod_counter: MODULUS must be 2..10**NDIG");
    end

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_nxt;
    logic [W-1:0] wrap_val;
    logic         at_tv;
    logic         at_zero;
    logic         wrap;
    logic         load_ok;

    // A full borrow out of the top digit means that every digit is zero.
    assign at_tv    = (cnt_q == TV);
    assign wrap     = up_dn ? at_tv : at_zero;
    assign wrap_val = up_dn ? '0 : TV;
    assign co       = en & ~clr & ~load & ~reset & wrap;

    // Packed BCD orders the same as its decimal value, so comparing against TV is a range check.
    assign load_ok  = bcd_valid(16'(load_val), NDIG) && (load_val <= TV);

    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        logic c_in_g;
        logic c_out_g;
        if (g == 0) begin : g_lsd
            assign c_in_g = 1'b1;
        end else begin : g_rip
            assign c_in_g = g_dig[g-1].c_out_g;
        end
        bcd_digit u_digit (
            .d_in     (cnt_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .up_dn    (up_dn),
            .c_in     (c_in_g),
            .wrap     (wrap),
            .wrap_val (wrap_val[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .d_out    (cnt_nxt[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .c_out    (c_out_g)
        );
    end

    assign at_zero = g_dig[NDIG-1].c_out_g & ~up_dn;

    // Live count and load error pulse; priority is reset > clr > load > en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            load_err <= 1'b0;
        end else if (clr) begin
            cnt_q    <= '0;
            load_err <= 1'b0;
        end else if (load) begin
            if (load_ok) begin
                cnt_q    <= load_val;
                load_err <= 1'b0;
            end else begin
                load_err <= 1'b1;
            end
        end else begin
            load_err <= 1'b0;
            if (en) begin
                cnt_q <= cnt_nxt;
            end
        end
    end

`ifdef BCD_CNT_LAP_EN
    logic [W-1:0] shadow_q;

    // Each lap pulse toggles the frozen display. clr drops the frozen view so the cleared count shows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_active <= 1'b0;
            shadow_q   <= '0;
        end else if (clr) begin
            lap_active <= 1'b0;
        end else if (lap) begin
            if (!lap_active) begin
                shadow_q <= cnt_q;
            end
            lap_active <= ~lap_active;
        end
    end

    assign bcd = lap_active ? shadow_q : cnt_q;
`else
    assign bcd = cnt_q;
`endif

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Self-checking bench for bcd_mod_counter (NDIG=2, MODULUS=60) plus a
// seconds -> minutes cascade. The lap checks build when BCD_CNT_LAP_EN is defined.
module tb_bcd_mod_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, up_dn, clr, load;
    logic [7:0] load_val;
    logic [7:0] bcd;
    logic       co, load_err;

    logic       cas_en;
    logic [7:0] sec_bcd, min_bcd;
    logic       sec_co, min_co, sec_err, min_err;

    int checks = 0;
    int errors = 0;

`ifdef BCD_CNT_LAP_EN
    logic lap, lap_active, lap_act_s, lap_act_m;
`endif

    always #5 clk = ~clk;

    bcd_mod_counter #(.NDIG(2), .MODULUS(60)) dut (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr),
        .load(load), .load_val(load_val), .bcd(bcd), .co(co), .load_err(load_err)
`ifdef BCD_CNT_LAP_EN
        , .lap(lap), .lap_active(lap_active)
`endif
    );

    bcd_mod_counter #(.NDIG(2), .MODULUS(60)) u_sec (
        .clk(clk), .reset(reset), .en(cas_en), .up_dn(1'b1), .clr(1'b0),
        .load(1'b0), .load_val(8'h00), .bcd(sec_bcd), .co(sec_co), .load_err(sec_err)
`ifdef BCD_CNT_LAP_EN
        , .lap(1'b0), .lap_active(lap_act_s)
`endif
    );

    bcd_mod_counter #(.NDIG(2), .MODULUS(60)) u_min (
        .clk(clk), .reset(reset), .en(sec_co), .up_dn(1'b1), .clr(1'b0),
        .load(1'b0), .load_val(8'h00), .bcd(min_bcd), .co(min_co), .load_err(min_err)
`ifdef BCD_CNT_LAP_EN
        , .lap(1'b0), .lap_active(lap_act_m)
`endif
    );

    typedef struct {
        logic       en;
        logic       up_dn;
        logic       clr;
        logic       load;
        logic [7:0] lv;
        logic       exp_co;
        logic [7:0] exp_bcd;
        logic       exp_err;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    initial begin
        //           en    up    clr   load  lv     co    bcd    err
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h47, 1'b0, 8'h47, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h6A, 1'b0, 8'h47, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h47, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h61, 1'b0, 8'h47, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h48, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 8'h00, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h59, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h59, 1'b0, 8'h59, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h0A, 1'b0, 8'h00, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h60, 1'b0, 8'h00, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0};

        reset = 1'b1; en = 1'b1; up_dn = 1'b1; clr = 1'b0; load = 1'b0;
        load_val = 8'h00; cas_en = 1'b0;
`ifdef BCD_CNT_LAP_EN
        lap = 1'b0;
`endif
        #2;
        check("reset_bcd", 32'(bcd), 32'h00);
        check("reset_err", 32'(load_err), 32'h0);
        check("reset_co", 32'(co), 32'h0);
        tick();
        tick();
        check("reset_hold_bcd", 32'(bcd), 32'h00);
        reset = 1'b0;

        // Up count through the full modulus; co is high only at 59.
        for (int m = 0; m < 60; m++) begin
            check($sformatf("up_co_%0d", m), 32'(co), 32'(m == 59));
            tick();
            check($sformatf("up_bcd_%0d", m), 32'(bcd), 32'(bcd2((m + 1) % 60)));
        end

        // Down from zero wraps to 59, then 58. A direction flip steps back up.
        up_dn = 1'b0;
        #1;
        check("dn_co_zero", 32'(co), 32'h1);
        tick();
        check("dn_wrap", 32'(bcd), 32'h59);
        check("dn_co_59", 32'(co), 32'h0);
        tick();
        check("dn_58", 32'(bcd), 32'h58);
        up_dn = 1'b1;
        tick();
        check("flip_up_59", 32'(bcd), 32'h59);
        en = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_zero", 32'(bcd), 32'h00);

        // Table of load/clear/priority vectors.
        for (int i = 0; i < 14; i++) begin
            en = vecs[i].en; up_dn = vecs[i].up_dn; clr = vecs[i].clr;
            load = vecs[i].load; load_val = vecs[i].lv;
            #1;
            check($sformatf("vec%0d_co", i), 32'(co), 32'(vecs[i].exp_co));
            tick();
            check($sformatf("vec%0d_bcd", i), 32'(bcd), 32'(vecs[i].exp_bcd));
            check($sformatf("vec%0d_err", i), 32'(load_err), 32'(vecs[i].exp_err));
        end
        en = 1'b0; clr = 1'b0; load = 1'b0; up_dn = 1'b1;

        // Asynchronous reset between edges.
        load = 1'b1; load_val = 8'h33;
        tick();
        load = 1'b0;
        check("pre_rst_33", 32'(bcd), 32'h33);
        #2;
        en = 1'b1;
        reset = 1'b1;
        #1;
        check("async_rst_bcd", 32'(bcd), 32'h00);
        check("async_rst_co", 32'(co), 32'h0);
        tick();
        check("rst_hold_bcd", 32'(bcd), 32'h00);
        reset = 1'b0;
        #1;
        check("post_rst_co", 32'(co), 32'h0);
        tick();
        check("post_rst_first", 32'(bcd), 32'h01);
        en = 1'b0;

        // Cascade: seconds into minutes.
        cas_en = 1'b1;
        repeat (60) tick();
        check("cas60_sec", 32'(sec_bcd), 32'h00);
        check("cas60_min", 32'(min_bcd), 32'h01);
        repeat (3539) tick();
        check("cas_sec_59", 32'(sec_bcd), 32'h59);
        check("cas_min_59", 32'(min_bcd), 32'h59);
        check("cas_sec_co", 32'(sec_co), 32'h1);
        check("cas_min_co", 32'(min_co), 32'h1);
        tick();
        check("cas_sec_wrap", 32'(sec_bcd), 32'h00);
        check("cas_min_wrap", 32'(min_bcd), 32'h00);
        check("cas_min_co_off", 32'(min_co), 32'h0);
        cas_en = 1'b0;

`ifdef BCD_CNT_LAP_EN
        // Lap freezes the display while the live count keeps running.
        load = 1'b1; load_val = 8'h12;
        tick();
        load = 1'b0;
        lap = 1'b1;
        tick();
        lap = 1'b0;
        check("lap_active_on", 32'(lap_active), 32'h1);
        check("lap_shadow", 32'(bcd), 32'h12);
        en = 1'b1;
        repeat (5) tick();
        en = 1'b0;
        check("lap_frozen", 32'(bcd), 32'h12);
        lap = 1'b1;
        tick();
        lap = 1'b0;
        check("lap_active_off", 32'(lap_active), 32'h0);
        check("lap_live", 32'(bcd), 32'h17);
        lap = 1'b1;
        tick();
        lap = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("lap_clr", 32'(lap_active), 32'h0);
        check("lap_clr_bcd", 32'(bcd), 32'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
